sysid_info_regs: RTL and testbench

SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

---
 rtl/sysid_info_pkg.sv | 41 ++++
 rtl/sysid_uptime_ctr.sv | 48 ++++
 rtl/sysid_info_regs.sv | 114 +++++++++++
 tb/tb_sysid_info_regs.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_info_pkg.sv
// Shared register map, CTRL bit positions and read-path constants for the
// system-ID info register block.
package sysid_info_pkg;

   localparam int unsigned ADDR_ID        = 0;
   localparam int unsigned ADDR_TIMESTAMP = 1;
   localparam int unsigned ADDR_UPTIME_LO = 2;
   localparam int unsigned ADDR_UPTIME_HI = 3;
   localparam int unsigned ADDR_SCRATCH   = 4;
   localparam int unsigned ADDR_CTRL      = 5;
   localparam int unsigned ADDR_USER_BASE = 6;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT = 1;
   localparam int unsigned CTRL_OVF_BIT = 2;

   localparam int unsigned READ_LATENCY = 1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_ID,
      SEL_TIMESTAMP,
      SEL_UPTIME_LO,
      SEL_UPTIME_HI,
      SEL_SCRATCH,
      SEL_CTRL,
      SEL_USER
   } reg_sel_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with enable, clear pulse, sticky overflow and a
// shadow of the upper word captured whenever the low word is read.
module sysid_uptime_ctr #(
   parameter int unsigned UPTIME_W = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en_we,
   input  logic        en_wdata,
   input  logic        clr,
   input  logic        ovf_clr,
   input  logic        snap,
   output logic [31:0] count_lo,
   output logic [31:0] shadow,
   output logic        en,
   output logic        ovf
);

   logic [UPTIME_W-1:0] count;
   logic                wrap;

   // A clear on the wrap edge wins, so no overflow is recorded for that cycle.
   assign wrap     = en && !clr && (count == '1);
   assign count_lo = count[31:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         count  <= '0;
         shadow <= '0;
         en     <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (clr) begin
            count <= '0;
         end else if (en) begin
            count <= count + UPTIME_W'(1);
         end
         if (snap) shadow <= 32'(count[UPTIME_W-1:32]);
         if (en_we) en <= en_wdata;
         if (wrap) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sysid_info_regs.sv
// Avalon-MM read-mostly register block: ID, build timestamp, uptime counter,
// scratch, control and user info words, with fixed one-cycle read latency.
module sysid_info_regs
   import sysid_info_pkg::*;
#(
   parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
   parameter int unsigned NUM_USER  = 4,
   parameter int unsigned UPTIME_W  = 64,
   parameter int unsigned ADDR_W    = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     address,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           writedata,
   input  logic [3:0]            byteenable,
   input  logic [32*NUM_USER-1:0] user_info,
   output logic [31:0]           readdata,
   output logic                  readdatavalid
);

   if (ADDR_USER_BASE + NUM_USER > (1 << ADDR_W)) begin : g_addr_check
      $fatal(1, "sysid_info_regs: ADDR_W too small for NUM_USER");
   end
   if (NUM_USER < 1 || NUM_USER > 8) begin : g_user_check
      $fatal(1, "sysid_info_regs: NUM_USER out of range 1..8");
   end
   if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_width_check
      $fatal(1, "sysid_info_regs: UPTIME_W out of range 33..64");
   end
   if (READ_LATENCY != 1) begin : g_latency_check
      $fatal(1, "sysid_info_regs: read path is a single register stage");
   end

   reg_sel_e    sel;
   int unsigned addr_idx;
   logic [31:0] user_word;
   logic [31:0] ctrl_word;
   logic [31:0] rd_mux;
   logic [31:0] scratch;
   logic [31:0] count_lo;
   logic [31:0] shadow;
   logic        en;
   logic        ovf;
   logic        ctrl_we;

   always_comb begin
      addr_idx  = 32'(address);
      sel       = SEL_NONE;
      user_word = '0;
      if      (addr_idx == ADDR_ID)        sel = SEL_ID;
      else if (addr_idx == ADDR_TIMESTAMP) sel = SEL_TIMESTAMP;
      else if (addr_idx == ADDR_UPTIME_LO) sel = SEL_UPTIME_LO;
      else if (addr_idx == ADDR_UPTIME_HI) sel = SEL_UPTIME_HI;
      else if (addr_idx == ADDR_SCRATCH)   sel = SEL_SCRATCH;
      else if (addr_idx == ADDR_CTRL)      sel = SEL_CTRL;
      else if (addr_idx >= ADDR_USER_BASE && addr_idx < ADDR_USER_BASE + NUM_USER)
         sel = SEL_USER;
      for (int unsigned k = 0; k < NUM_USER; k++) begin
         if (addr_idx == ADDR_USER_BASE + k) user_word = user_info[32*k +: 32];
      end
   end

   always_comb begin
      ctrl_word               = '0;
      ctrl_word[CTRL_EN_BIT]  = en;
      ctrl_word[CTRL_OVF_BIT] = ovf;
      case (sel)
         SEL_ID:        rd_mux = ID_VALUE;
         SEL_TIMESTAMP: rd_mux = TIMESTAMP;
         SEL_UPTIME_LO: rd_mux = count_lo;
         SEL_UPTIME_HI: rd_mux = shadow;
         SEL_SCRATCH:   rd_mux = scratch;
         SEL_CTRL:      rd_mux = ctrl_word;
         SEL_USER:      rd_mux = user_word;
         default:       rd_mux = '0;
      endcase
   end

   assign ctrl_we = write && (sel == SEL_CTRL);

   sysid_uptime_ctr #(
      .UPTIME_W (UPTIME_W)
   ) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .en_we    (ctrl_we),
      .en_wdata (writedata[CTRL_EN_BIT]),
      .clr      (ctrl_we && writedata[CTRL_CLR_BIT]),
      .ovf_clr  (ctrl_we && writedata[CTRL_OVF_BIT]),
      .snap     (read && (sel == SEL_UPTIME_LO)),
      .count_lo (count_lo),
      .shadow   (shadow),
      .en       (en),
      .ovf      (ovf)
   );

   // Readback samples pre-write state, so a same-cycle write is not visible.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch       <= '0;
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         if (write && (sel == SEL_SCRATCH))
            scratch <= merge_bytes(scratch, writedata, byteenable);
         readdatavalid <= read;
         if (read) readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench: directed register-map scenarios followed by random
// traffic, all compared each cycle against a transaction-level model.
module tb_sysid_info_regs;

   localparam int unsigned UW      = 33;
   localparam logic [63:0] MAX_CNT = (64'd1 << UW) - 64'd1;
   localparam logic [31:0] ID_V    = 32'h1234_5678;
   localparam logic [31:0] TS_V    = 32'h5563_1347;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   address;
   logic         read;
   logic         write;
   logic [31:0]  writedata;
   logic [3:0]   byteenable;
   logic [127:0] user_info;
   logic [31:0]  readdata;
   logic         readdatavalid;

   int errors = 0;
   int checks = 0;

   sysid_info_regs #(
      .ID_VALUE  (ID_V),
      .TIMESTAMP (TS_V),
      .NUM_USER  (4),
      .UPTIME_W  (UW),
      .ADDR_W    (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .user_info     (user_info),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   logic [63:0] m_cnt;
   logic [31:0] m_shadow, m_scratch, m_rdata;
   logic        m_en, m_ovf, m_valid;
   logic        live = 1'b0;
   logic [63:0] force_val = '0;
   int          force_seq = 0;
   int          force_seen = 0;

   function automatic logic [31:0] reg_value(input int unsigned a);
      case (a)
         0: return ID_V;
         1: return TS_V;
         2: return m_cnt[31:0];
         3: return m_shadow;
         4: return m_scratch;
         5: return {29'd0, m_ovf, 1'b0, m_en};
         6, 7, 8, 9: return 32'(user_info >> (32 * (a - 6)));
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clock) begin : model
      int unsigned a;
      logic ctrl_wr, clr, w1c, wrap;
      logic [31:0] mask;
      if (force_seq != force_seen) begin
         m_cnt      = force_val;
         force_seen = force_seq;
      end
      live = 1'b1;
      if (reset) begin
         m_cnt = '0; m_shadow = '0; m_scratch = '0;
         m_en = 1'b1; m_ovf = 1'b0; m_valid = 1'b0; m_rdata = '0;
      end else begin
         a       = 32'(address);
         m_valid = read;
         if (read) m_rdata = reg_value(a);
         ctrl_wr = write && (a == 5);
         clr     = ctrl_wr && writedata[1];
         w1c     = ctrl_wr && writedata[2];
         if (read && a == 2) m_shadow = 32'(m_cnt >> 32);
         if (write && a == 4) begin
            mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
            m_scratch = (m_scratch & ~mask) | (writedata & mask);
         end
         wrap = !clr && m_en && (m_cnt == MAX_CNT);
         if (clr) m_cnt = '0;
         else if (m_en) m_cnt = (m_cnt + 64'd1) & MAX_CNT;
         if (wrap) m_ovf = 1'b1;
         else if (w1c) m_ovf = 1'b0;
         if (ctrl_wr) m_en = writedata[0];
      end
   end

   always @(negedge clock) begin
      if (live) begin
         checks++;
         if (readdatavalid !== m_valid || readdata !== m_rdata) begin
            errors++;
            if (errors < 40)
               $display("FAIL cycle t=%0t: got valid=%b data=%h expected valid=%b data=%h",
                        $time, readdatavalid, readdata, m_valid, m_rdata);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      address = a; read = 1'b1; write = 1'b0;
      @(posedge clock); #1;
      d = readdata;
      check("rdvalid", 32'(readdatavalid), 32'd1);
      @(negedge clock);
      read = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      address = a; write = 1'b1; read = 1'b0; writedata = d; byteenable = be;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic rdwr(input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
      address = a; write = 1'b1; read = 1'b1; writedata = d; byteenable = 4'hF;
      @(posedge clock); #1;
      q = readdata;
      @(negedge clock);
      write = 1'b0; read = 1'b0;
   endtask

   task automatic set_count(input logic [63:0] v);
      force_val = v;
      force dut.u_ctr.count = force_val[UW-1:0];
      release dut.u_ctr.count;
      force_seq++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, lo_a, lo_b;
      reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
      writedata = '0; byteenable = '0;
      for (int k = 0; k < 4; k++) user_info[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
      repeat (3) @(posedge clock);
      #1;
      check("reset_data", readdata, 32'd0);
      check("reset_valid", 32'(readdatavalid), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      rd(4'd0, d); check("id", d, 32'h1234_5678);
      rd(4'd1, d); check("timestamp", d, 32'h5563_1347);

      wr(4'd4, 32'hAABB_CCDD, 4'b1111);
      wr(4'd4, 32'h1122_3344, 4'b0101);
      rd(4'd4, d); check("scratch_lanes", d, 32'hAA22_CC44);

      // Upper word 1 at the LO read; the counter wraps to 0 before HI is read.
      set_count(64'h1_FFFF_FFF8);
      rd(4'd2, d); check("lo_snap", d, 32'hFFFF_FFF8);
      repeat (10) @(negedge clock);
      rd(4'd3, d); check("hi_shadow", d, 32'd1);
      rd(4'd5, d); check("ovf_set", d, 32'h5);

      set_count(MAX_CNT);
      wr(4'd5, 32'h5, 4'hF);
      rd(4'd5, d); check("ovf_set_wins", d, 32'h5);
      wr(4'd5, 32'h5, 4'hF);
      rd(4'd5, d); check("ovf_w1c", d, 32'h1);

      wr(4'd5, 32'h0, 4'hF);
      rd(4'd2, lo_a);
      repeat (5) @(negedge clock);
      rd(4'd2, lo_b); check("lo_hold", lo_b, lo_a);
      rd(4'd5, d); check("en_off", d, 32'h0);
      wr(4'd5, 32'h3, 4'hF);
      rd(4'd2, d); check("lo_after_clr_small", 32'(d <= 32'd3), 32'd1);

      rdwr(4'd4, 32'h0BAD_F00D, d); check("rw_pre_value", d, 32'hAA22_CC44);
      rd(4'd4, d); check("rw_post_value", d, 32'h0BAD_F00D);

      for (int k = 0; k < 4; k++) begin
         rd(4'(6 + k), d); check("user", d, 32'hC0DE_0000 + 32'(k));
      end
      rd(4'd15, d); check("unmapped", d, 32'd0);
      wr(4'd12, 32'hFFFF_FFFF, 4'hF);
      rd(4'd12, d); check("unmapped_wr", d, 32'd0);

      address = 4'd0; read = 1'b1;
      @(negedge clock);
      read = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      check("reset_drop_valid", 32'(readdatavalid), 32'd0);
      check("reset_drop_data", readdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         address    = 4'($urandom_range(0, 15));
         read       = 1'($urandom_range(0, 1));
         write      = ($urandom_range(0, 2) == 0);
         writedata  = $urandom;
         byteenable = 4'($urandom);
         if (address == 4'd5) begin
            writedata[0] = ($urandom_range(0, 3) != 0);
            writedata[1] = ($urandom_range(0, 7) == 0);
         end
         user_info  = {$urandom, $urandom, $urandom, $urandom};
         reset      = ($urandom_range(0, 599) == 0);
         if (i % 400 == 200) set_count(MAX_CNT - 64'($urandom_range(0, 20)));
         @(negedge clock);
      end
      reset = 1'b0; read = 1'b0; write = 1'b0;
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
